// File: rtl/password_pkg.sv
//------------------------------------------------------------------------------
// Module  : password_pkg
// Brief   : Shared state encodings, digit width and BCD check for the lock core
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package password_pkg;

    localparam int unsigned c_DIGIT_W = 4;

    localparam logic [2:0] c_ST_ENTRY   = 3'd0;
    localparam logic [2:0] c_ST_CHECK   = 3'd1;
    localparam logic [2:0] c_ST_OPEN    = 3'd2;
    localparam logic [2:0] c_ST_LOCKOUT = 3'd3;
    localparam logic [2:0] c_ST_SET     = 3'd4;

    function automatic logic is_bcd(input logic [c_DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwn_timer.sv
//------------------------------------------------------------------------------
// Module  : dwn_timer
// Brief   : Loadable down-counter; done_o flags the final counted cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dwn_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_a_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/password_lock_core.sv
//------------------------------------------------------------------------------
// Module  : password_lock_core
// Brief   : Keypad lock: code entry, compare, retry limit, lockout and relock
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module password_lock_core
    import password_pkg::*;
#(
    parameter int unsigned     DIGITS         = 4,
    parameter int unsigned     MAX_TRIES      = 3,
    parameter int unsigned     LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned     OPEN_CYCLES    = 250_000_000,
    parameter logic [4*DIGITS-1:0] INIT_CODE  = 16'h1234
) (
    input  logic                 clk,
    input  logic                 rst_a_n,
    input  logic [c_DIGIT_W-1:0] digit_i,
    input  logic                 digit_valid_i,
    input  logic                 clear_i,
    input  logic                 lock_i,
    input  logic                 change_i,
    output logic                 unlocked_o,
    output logic                 fail_o,
    output logic                 lockout_o,
    output logic                 setmode_o,
    output logic [3:0]           tries_left_o,
    output logic [3:0]           digit_count_o,
    output logic [2:0]           state_o
);

    localparam int unsigned c_CODE_W  = c_DIGIT_W * DIGITS;
    localparam int unsigned c_TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int unsigned c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam logic [c_TMR_W-1:0] c_LOCK_LOAD = c_TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_OPEN_LOAD = c_TMR_W'(OPEN_CYCLES - 1);
    localparam logic [3:0] c_TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] c_LAST_IDX   = 4'(DIGITS - 1);

    logic [2:0]          state_q,  state_d;
    logic [c_CODE_W-1:0] code_q,   code_d;
    logic [c_CODE_W-1:0] buf_q,    buf_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [3:0]          tries_q,  tries_d;
    logic                fail_q,   fail_d;

    logic [c_CODE_W-1:0] w_shifted;
    logic                w_digit_ok;
    logic                w_last;
    logic                w_tmr_load;
    logic [c_TMR_W-1:0]  w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_done;

    generate
        if (DIGITS == 1) begin : g_shift_one
            assign w_shifted = digit_i;
        end else begin : g_shift_multi
            assign w_shifted = {buf_q[c_CODE_W-c_DIGIT_W-1:0], digit_i};
        end
    endgenerate

    assign w_digit_ok = digit_valid_i && is_bcd(digit_i);
    assign w_last     = (cnt_q == c_LAST_IDX);

    // Any state change restarts the shared timer, so OPEN and LOCKOUT always count from entry.
    assign w_tmr_load = (state_d != state_q);
    assign w_tmr_val  = (state_d == c_ST_LOCKOUT) ? c_LOCK_LOAD : c_OPEN_LOAD;
    assign w_tmr_en   = (state_q == c_ST_OPEN) || (state_q == c_ST_LOCKOUT);

    dwn_timer #(
        .WIDTH      (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_a_n    (rst_a_n),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .done_o     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q <= c_ST_ENTRY;
            code_q  <= INIT_CODE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tries_q <= c_TRIES_INIT;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        fail_d  = 1'b0;
        case (state_q)
            c_ST_ENTRY: begin
                if (clear_i) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (w_digit_ok) begin
                    buf_d = w_shifted;
                    cnt_d = cnt_q + 4'd1;
                    if (w_last) begin
                        state_d = c_ST_CHECK;
                    end
                end
            end
            c_ST_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == code_q) begin
                    state_d = c_ST_OPEN;
                    tries_d = c_TRIES_INIT;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = (tries_q != 4'd0) ? tries_q - 4'd1 : 4'd0;
                    state_d = (tries_q <= 4'd1) ? c_ST_LOCKOUT : c_ST_ENTRY;
                end
            end
            c_ST_OPEN: begin
                if (lock_i || w_tmr_done) begin
                    state_d = c_ST_ENTRY;
                end else if (change_i) begin
                    state_d = c_ST_SET;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            c_ST_SET: begin
                if (clear_i) begin
                    state_d = c_ST_OPEN;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (w_digit_ok) begin
                    if (w_last) begin
                        code_d  = w_shifted;
                        state_d = c_ST_ENTRY;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        buf_d = w_shifted;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            c_ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    state_d = c_ST_ENTRY;
                    tries_d = c_TRIES_INIT;
                end
            end
            default: begin
                state_d = c_ST_ENTRY;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        unlocked_o    = (state_q == c_ST_OPEN);
        lockout_o     = (state_q == c_ST_LOCKOUT);
        setmode_o     = (state_q == c_ST_SET);
        fail_o        = fail_q;
        tries_left_o  = tries_q;
        digit_count_o = cnt_q;
        state_o       = state_q;
    end

endmodule

`default_nettype wire
